control_sequencer: RTL

//  Microsequencer for the 8-bit shared-bus CPU. Steps the T-state FSM (fetch, then a

---
 rtl/control_sequencer_if.sv | 24 ++
 rtl/control_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control-sequencer bus: run/step front panel, IR and flags in; control word and status out.
// The master side is the CPU datapath/front panel; the slave side is the sequencer itself.
interface control_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  run;
    logic                  step;
    logic [DATA_WIDTH-1:0] ir;
    logic                  flag_c;
    logic                  flag_z;
    logic [15:0]           ctrl;
    logic [2:0]            tstate;
    logic                  halted;

    modport master (
        output run, step, ir, flag_c, flag_z,
        input  ctrl, tstate, halted
    );

    modport slave (
        input  run, step, ir, flag_c, flag_z,
        output ctrl, tstate, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Microsequencer for the 8-bit shared-bus CPU: fetch/execute T-state FSM plus the
// opcode/flag decode into the 16-bit control word, changing on posedge for negedge-latching registers.
module control_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    control_sequencer_if.slave bus
);
    localparam logic [15:0] PC_OE    = 16'h0001;
    localparam logic [15:0] PC_STEP  = 16'h0002;
    localparam logic [15:0] PC_IE    = 16'h0004;
    localparam logic [15:0] MAR_IE   = 16'h0008;
    localparam logic [15:0] RAM_OE   = 16'h0010;
    localparam logic [15:0] RAM_IE   = 16'h0020;
    localparam logic [15:0] IR_IE    = 16'h0040;
    localparam logic [15:0] IR_OE    = 16'h0080;
    localparam logic [15:0] A_IE     = 16'h0100;
    localparam logic [15:0] A_OE     = 16'h0200;
    localparam logic [15:0] B_IE     = 16'h0400;
    localparam logic [15:0] ALU_OE   = 16'h0800;
    localparam logic [15:0] ALU_SUB  = 16'h1000;
    localparam logic [15:0] FLAGS_IE = 16'h2000;
    localparam logic [15:0] OUT_IE   = 16'h4000;
    localparam logic [15:0] HLT      = 16'h8000;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        E0   = 3'd2,
        E1   = 3'd3,
        E2   = 3'd4,
        HALT = 3'd7
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    step_q;
    logic                    adv;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [OPCODE_WIDTH+3:0] op_ext;
    logic [3:0]              op;
    logic [15:0]             word;
    logic                    unused_bits;

    // Zero-extend before taking the low nibble so any OPCODE_WIDTH decodes cleanly.
    assign opcode      = bus.ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign op_ext      = {4'b0000, opcode};
    assign op          = op_ext[3:0];
    assign unused_bits = ^{bus.ir, op_ext};

    assign adv = bus.run | (bus.step & ~step_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= F0;
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
            if (adv) begin
                state <= state_nxt;
            end
        end
    end

    always_comb begin
        word      = '0;
        state_nxt = F0;
        case (state)
            F0: begin
                word      = PC_OE | MAR_IE;
                state_nxt = F1;
            end
            F1: begin
                word      = RAM_OE | IR_IE | PC_STEP;
                state_nxt = E0;
            end
            E0: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        word      = IR_OE | MAR_IE;
                        state_nxt = E1;
                    end
                    OP_LDI: word = IR_OE | A_IE;
                    OP_JMP: word = IR_OE | PC_IE;
                    OP_JC:  word = bus.flag_c ? (IR_OE | PC_IE) : 16'h0000;
                    OP_JZ:  word = bus.flag_z ? (IR_OE | PC_IE) : 16'h0000;
                    OP_OUT: word = A_OE | OUT_IE;
                    OP_HLT: begin
                        word      = HLT;
                        state_nxt = HALT;
                    end
                    default: word = 16'h0000;
                endcase
            end
            E1: begin
                case (op)
                    OP_LDA: word = RAM_OE | A_IE;
                    OP_ADD, OP_SUB: begin
                        word      = RAM_OE | B_IE;
                        state_nxt = E2;
                    end
                    OP_STA: word = A_OE | RAM_IE;
                    default: word = 16'h0000;
                endcase
            end
            E2: begin
                if (op == OP_ADD) begin
                    word = ALU_OE | A_IE | FLAGS_IE;
                end else if (op == OP_SUB) begin
                    word = ALU_OE | A_IE | FLAGS_IE | ALU_SUB;
                end
            end
            HALT: begin
                word      = HLT;
                state_nxt = HALT;
            end
            default: begin
                word      = '0;
                state_nxt = F0;
            end
        endcase
    end

    // Outside HALT the word is gated by adv so nothing on the bus acts while paused.
    always_comb begin
        bus.ctrl = '0;
        if (!rst && (state == HALT || adv)) begin
            bus.ctrl = word;
        end
    end

    assign bus.tstate = state;
    assign bus.halted = (state == HALT);

    // OP_NOP is listed for readability of the decode table; it falls through to default.
    localparam logic [3:0] OP_NOP_ALIAS = OP_NOP;
endmodule
